// File: rtl/dct_2d_sched_pkg.sv
// Shared control types for the 2-D DCT datapath: FSM states, vector index type and
// the default pass length / wait budget used by the scheduler, stage and transpose buffer.
package dct_ctrl_pkg;

  localparam int DCT_DIM     = 8;
  localparam int DCT_TIMEOUT = 64;
  localparam int VEC_W       = $clog2(DCT_DIM);

  typedef logic [VEC_W-1:0] vec_idx_t;

  typedef enum logic [2:0] {
    IDLE, CLR1, FEED1, WAIT1, CLR2, FEED2, WAIT2, OUT
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == WAIT1) || (s == WAIT2);
  endfunction

endpackage

// File: rtl/dct_2d_sched_if.sv
// Block handshake plus stage control bundle between the scheduler (master) and its
// surroundings: block source, dct stage, transpose buffer and quantizer (slave).
interface dct_sched_if #(parameter int CNT_W = 16) ();

  logic                     blk_valid;
  logic                     blk_ready;
  logic                     approx_req;
  logic                     stage_clr;
  logic                     stage_en;
  dct_ctrl_pkg::vec_idx_t   vec_idx;
  logic                     pass_sel;
  logic                     approx_en;
  logic                     stage_done;
  logic                     cap_en;
  logic                     out_valid;
  logic                     out_ready;
  logic                     err_timeout;
  logic [CNT_W-1:0]         blk_cnt;

  modport master (
    input  blk_valid, approx_req, stage_done, out_ready,
    output blk_ready, stage_clr, stage_en, vec_idx, pass_sel, approx_en,
           cap_en, out_valid, err_timeout, blk_cnt
  );

  modport slave (
    output blk_valid, approx_req, stage_done, out_ready,
    input  blk_ready, stage_clr, stage_en, vec_idx, pass_sel, approx_en,
           cap_en, out_valid, err_timeout, blk_cnt
  );

endinterface

// File: rtl/dct_2d_sched_wait_timer.sv
// Loadable up-counter that flags expiry once TIMEOUT cycles have been counted;
// it stops at TIMEOUT so the flag stays up until the next load.
module dct_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && !expired_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/dct_2d_sched.sv
// Drives one shared dct stage through the column pass, transpose capture and row pass
// of an 8x8 block, with block-level valid/ready on both sides and a wait-state watchdog.
module dct_2d_sched
  import dct_ctrl_pkg::*;
#(
  parameter int DIM     = DCT_DIM,
  parameter int TIMEOUT = DCT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  dct_sched_if.master  bus
);

  state_e           state_q, state_d;
  vec_idx_t         vec_q, vec_d;
  logic             approx_q, approx_d;
  logic             err_q, err_d;
  logic             abort_clr_q, abort_clr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             feeding;
  logic             expired;

  assign feeding = (state_q == FEED1) || (state_q == FEED2);

  // Timer is reloaded throughout each feed run so it reads zero on the first WAIT cycle.
  dct_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (feeding),
    .en_i      (is_wait(state_q)),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    approx_d    = approx_q;
    err_d       = err_q;
    abort_clr_d = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.blk_valid) begin
          approx_d = bus.approx_req;
          state_d  = CLR1;
        end
      end
      CLR1: begin
        vec_d   = '0;
        state_d = FEED1;
      end
      FEED1, FEED2: begin
        vec_d = vec_idx_t'(vec_q + 1'b1);
        if (vec_q == vec_idx_t'(DIM - 1)) begin
          vec_d   = '0;
          state_d = (state_q == FEED1) ? WAIT1 : WAIT2;
        end
      end
      WAIT1, WAIT2: begin
        // stage_done beats an expiring timer in the same cycle.
        if (bus.stage_done) begin
          state_d = (state_q == WAIT1) ? CLR2 : OUT;
        end else if (expired) begin
          err_d       = 1'b1;
          abort_clr_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CLR2: begin
        vec_d   = '0;
        state_d = FEED2;
      end
      OUT: begin
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      approx_q    <= 1'b0;
      err_q       <= 1'b0;
      abort_clr_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      approx_q    <= approx_d;
      err_q       <= err_d;
      abort_clr_q <= abort_clr_d;
      cnt_q       <= cnt_d;
    end
  end

  // cap_en is the one deliberate input-to-output path: the buffer must latch in the done cycle.
  assign bus.blk_ready   = (state_q == IDLE);
  assign bus.stage_clr   = (state_q == CLR1) || (state_q == CLR2) || abort_clr_q;
  assign bus.stage_en    = feeding;
  assign bus.vec_idx     = feeding ? vec_q : '0;
  assign bus.pass_sel    = (state_q == CLR2) || (state_q == FEED2) ||
                           (state_q == WAIT2) || (state_q == OUT);
  assign bus.approx_en   = approx_q && (state_q != IDLE);
  assign bus.cap_en      = (state_q == WAIT1) && bus.stage_done;
  assign bus.out_valid   = (state_q == OUT);
  assign bus.err_timeout = err_q;
  assign bus.blk_cnt     = cnt_q;

endmodule

// File: tb/tb_dct_2d_sched.sv
// Directed bench for dct_2d_sched: cycle-accurate output tables per scenario, plus a
// 2-bit counter instance fed the same stimulus to show blk_cnt wrapping.
module tb_dct_2d_sched;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   expCnt      = 0;
  logic expErr      = 1'b0;

  dct_sched_if #(.CNT_W(16)) bus ();
  dct_sched_if #(.CNT_W(2))  busSmall ();

  dct_2d_sched #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dct_2d_sched #(.CNT_W(2)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busSmall)
  );

  assign busSmall.blk_valid  = bus.blk_valid;
  assign busSmall.approx_req = bus.approx_req;
  assign busSmall.stage_done = bus.stage_done;
  assign busSmall.out_ready  = bus.out_ready;

  always #5 clk = ~clk;

  // Observation order: blk_ready, stage_clr, stage_en, vec_idx[2:0], pass_sel,
  // approx_en, cap_en, out_valid, err_timeout, blk_cnt[15:0].
  logic [26:0] obsVec;
  assign obsVec = {bus.blk_ready, bus.stage_clr, bus.stage_en, bus.vec_idx, bus.pass_sel,
                   bus.approx_en, bus.cap_en, bus.out_valid, bus.err_timeout, bus.blk_cnt};

  task automatic applyIdle();
    bus.blk_valid  = 1'b0;
    bus.approx_req = 1'b0;
    bus.stage_done = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  // One block accepted at t=0; done1/done2 are the stage_done cycles, hold is the number
  // of OUT cycles with out_ready low, spur adds done pulses in FEED1 (t=5) and CLR2.
  task automatic run_block(input string tag, input int d1, input int d2, input int hold,
                           input bit apx, input bit spur);
    logic [26:0] expVec;
    logic        feed1, feed2;
    logic [2:0]  v;
    int          last;
    last = d2 + hold + 2;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      bus.blk_valid  = (t == 0);
      bus.approx_req = (t == 0) ? apx : 1'b0;
      bus.stage_done = (t == d1) || (t == d2) || (spur && (t == 5 || t == d1 + 1));
      bus.out_ready  = (t >= d2 + 1 + hold);
      #1;
      feed1 = (t >= 2) && (t <= 9);
      feed2 = (t >= d1 + 2) && (t <= d1 + 9);
      v     = feed1 ? 3'(t - 2) : (feed2 ? 3'(t - d1 - 2) : 3'd0);
      expVec = {(t == 0) || (t == last),
                (t == 1) || (t == d1 + 1),
                feed1 || feed2,
                v,
                (t >= d1 + 1) && (t <= last - 1),
                apx && (t >= 1) && (t <= last - 1),
                (t == d1),
                (t >= d2 + 1) && (t <= last - 1),
                expErr,
                16'((t == last) ? expCnt + 1 : expCnt)};
      testsRun++;
      if (obsVec !== expVec) begin
        testsFailed++;
        $display("[TB] FAIL %s t=%0d got=%h want=%h", tag, t, obsVec, expVec);
      end
    end
    expCnt++;
    applyIdle();
  endtask

  task automatic test_reset();
    applyIdle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if (obsVec !== {1'b1, 10'b0, 16'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reset got=%h want=%h", obsVec, {1'b1, 10'b0, 16'd0});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_block("basic", 12, 24, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block("backpressure", 12, 24, 5, 1'b0, 1'b0);
  endtask

  task automatic test_approx();
    run_block("approx", 12, 24, 0, 1'b1, 1'b0);
  endtask

  task automatic test_spurious_done();
    run_block("spurious", 12, 24, 0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout();
    for (int t = 0; t <= 76; t++) begin
      @(posedge clk); #1;
      bus.blk_valid = (t == 0);
      #1;
      if (t == 74) begin
        testsRun++;
        if (obsVec !== {10'b0, 1'b0, 16'(expCnt)}) begin
          testsFailed++;
          $display("[TB] FAIL timeout_wait got=%h want=%h", obsVec, {10'b0, 1'b0, 16'(expCnt)});
        end
      end
      if (t == 75) begin
        testsRun++;
        if (obsVec !== {2'b11, 8'b0, 1'b1, 16'(expCnt)}) begin
          testsFailed++;
          $display("[TB] FAIL timeout_abort got=%h want=%h", obsVec, {2'b11, 8'b0, 1'b1, 16'(expCnt)});
        end
      end
      if (t == 76) begin
        testsRun++;
        if (obsVec !== {1'b1, 9'b0, 1'b1, 16'(expCnt)}) begin
          testsFailed++;
          $display("[TB] FAIL timeout_idle got=%h want=%h", obsVec, {1'b1, 9'b0, 1'b1, 16'(expCnt)});
        end
      end
    end
    applyIdle();
    expErr = 1'b1;
    run_block("after_timeout", 12, 24, 0, 1'b0, 1'b0);
  endtask

  task automatic test_done_at_limit();
    run_block("done_at_limit", 74, 84, 0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int t = 0; t <= 17; t++) begin
      @(posedge clk); #1;
      bus.blk_valid  = (t == 0);
      bus.stage_done = (t == 12);
      rst            = (t == 16);
      #1;
      if (t == 16) begin
        testsRun++;
        if (obsVec !== {3'b001, 3'd2, 1'b1, 3'b000, 1'b1, 16'(expCnt)}) begin
          testsFailed++;
          $display("[TB] FAIL mid_reset_feed2 got=%h want=%h", obsVec,
                   {3'b001, 3'd2, 1'b1, 3'b000, 1'b1, 16'(expCnt)});
        end
      end
      if (t == 17) begin
        testsRun++;
        if (obsVec !== {1'b1, 10'b0, 16'd0} || busSmall.blk_cnt !== 2'd0) begin
          testsFailed++;
          $display("[TB] FAIL mid_reset_idle got=%h/%0d want=%h/0", obsVec, busSmall.blk_cnt,
                   {1'b1, 10'b0, 16'd0});
        end
      end
    end
    rst = 1'b0;
    applyIdle();
    expCnt = 0;
    expErr = 1'b0;
  endtask

  task automatic test_counter_wrap();
    run_block("wrap1", 12, 24, 0, 1'b0, 1'b0);
    run_block("wrap2", 12, 24, 0, 1'b0, 1'b0);
    testsRun++;
    if (busSmall.blk_cnt !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL wrap_mid got=%0d want=2", busSmall.blk_cnt);
    end
    run_block("wrap3", 12, 24, 0, 1'b0, 1'b0);
    run_block("wrap4", 12, 24, 0, 1'b0, 1'b0);
    testsRun++;
    if (busSmall.blk_cnt !== 2'd0 || bus.blk_cnt !== 16'd4) begin
      testsFailed++;
      $display("[TB] FAIL wrap_end got=%0d/%0d want=0/4", busSmall.blk_cnt, bus.blk_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyIdle();
    test_reset();
    test_basic();
    test_backpressure();
    test_approx();
    test_spurious_done();
    test_timeout();
    test_done_at_limit();
    test_mid_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
